mio_bus_nport: RTL

// - Parametrised successor to the single-cycle MIO address decoder: routes CPU load/store

---
 rtl/mio_bus_pkg.sv | 37 +++
 rtl/mio_addr_decode.sv | 37 +++
 rtl/mio_bus_nport.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mio_bus_pkg
// Description : Shared types and constants for the N-port MIO bus.
//               Holds the bus FSM state encoding, the default slave address
//               regions (addr[31:28]) and the timeout counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mio_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Default region nibbles (compared against addr[31:28])
    localparam logic [3:0] REG_RAM  = 4'h0;
    localparam logic [3:0] REG_VRAM = 4'hC;
    localparam logic [3:0] REG_KBD  = 4'hD;
    localparam logic [3:0] REG_SSEG = 4'hE;
    localparam logic [3:0] REG_PIO  = 4'hF;
    localparam logic [3:0] REG_PIC  = 4'hB;

    // Slave 0 sits in the least significant nibble
    localparam logic [23:0] DEF_REGION = {REG_PIC, REG_KBD, REG_VRAM,
                                          REG_PIO, REG_SSEG, REG_RAM};

    localparam int ERR_CNT_W = 8;

    // Counter only ever holds 0 .. timeout-1
    function automatic int tmo_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage : mio_bus_pkg
`default_nettype wire

// File: rtl/mio_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : mio_addr_decode
// Description : Combinational region decoder. Compares the address top
//               nibble against every slave region and returns a one-hot hit
//               vector; when regions overlap the lowest index wins.
// Ports       : i_nibble - addr[31:28]
//               o_hit    - one-hot slave hit (all zero on miss)
//               o_miss   - no slave claims the address
// Revision    : 1.0 - initial release
// ============================================================================
module mio_addr_decode
    import mio_bus_pkg::*;
#(
    parameter int                  NSLV       = 6,
    parameter logic [NSLV*4-1:0]   SLV_REGION = DEF_REGION
) (
    input  logic [3:0]      i_nibble,
    output logic [NSLV-1:0] o_hit,
    output logic            o_miss
);

    logic [NSLV-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NSLV; i++) begin
            w_match[i] = (i_nibble == SLV_REGION[4*i +: 4]);
        end
    end

    // Isolate the lowest set bit: x & -x
    assign o_hit  = w_match & (~w_match + NSLV'(1));
    assign o_miss = ~|w_match;

endmodule : mio_addr_decode
`default_nettype wire

// File: rtl/mio_bus_nport.sv
`default_nettype none
// ============================================================================
// Module      : mio_bus_nport
// Description : Routes CPU load/store requests to NSLV memory-mapped slaves
//               selected by addr[31:28]. Registers the request, waits for
//               the selected slave's ready with a timeout, and returns a
//               one-cycle ack with data or a bus error. Error responses are
//               tallied in a saturating 8-bit counter.
// Ports       : clk, rst (async, active high)
//               cpu_req/we/addr/wdata  -> request from CPU (held until ack)
//               cpu_ack/rdata/err      <- one-cycle response
//               slv_sel/we/addr/wdata  -> registered request to slaves
//               slv_rdata/ready        <- per-slave response (packed)
//               err_cnt                <- saturating error response count
// Revision    : 1.0 - initial release
// ============================================================================
module mio_bus_nport
    import mio_bus_pkg::*;
#(
    parameter int                NSLV       = 6,
    parameter int                DW         = 32,
    parameter logic [NSLV*4-1:0] SLV_REGION = DEF_REGION,
    parameter int                TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic                 cpu_ack,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_err,
    output logic [NSLV-1:0]      slv_sel,
    output logic                 slv_we,
    output logic [31:0]          slv_addr,
    output logic [DW-1:0]        slv_wdata,
    input  logic [NSLV*DW-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ready,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                 c_tmo_w    = tmo_width(TIMEOUT);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [NSLV-1:0]        w_hit;
    logic                   w_miss;
    logic                   w_sel_ready;
    logic [DW-1:0]          w_sel_rdata;
    logic                   w_tmo;

    logic [NSLV-1:0]        r_sel;
    logic                   r_we;
    logic [31:0]            r_addr;
    logic [DW-1:0]          r_wdata;
    logic                   r_ack;
    logic                   r_err;
    logic [DW-1:0]          r_rdata;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic [c_tmo_w-1:0]     r_cnt;

    mio_addr_decode #(
        .NSLV       (NSLV),
        .SLV_REGION (SLV_REGION)
    ) u_dec (
        .i_nibble (cpu_addr[31:28]),
        .o_hit    (w_hit),
        .o_miss   (w_miss)
    );

    // r_sel is one-hot, so an OR of masked slices is a clean mux
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_sel[i]) begin
                w_sel_rdata = w_sel_rdata | slv_rdata[DW*i +: DW];
            end
        end
    end

    assign w_sel_ready = |(slv_ready & r_sel);
    assign w_tmo       = (r_cnt == c_tmo_last);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (cpu_req) begin
                    w_state_nxt = w_miss ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_sel_ready || w_tmo) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture, timeout, response, error count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_err_cnt <= '0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_cnt   <= '0;
                        if (w_miss) begin
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_sel <= w_hit;
                            r_we  <= cpu_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b0;
                        // Stores return zero rather than whatever the slave drives
                        r_rdata <= r_we ? '0 : w_sel_rdata;
                        r_sel   <= '0;
                        r_we    <= 1'b0;
                    end else if (w_tmo) begin
                        r_ack   <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_sel   <= '0;
                        r_we    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_tmo_w'(1);
                    end
                end
                ST_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    if (r_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                    end
                end
                default: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack   = r_ack;
    assign cpu_err   = r_err;
    assign cpu_rdata = r_rdata;
    assign slv_sel   = r_sel;
    assign slv_we    = r_we;
    assign slv_addr  = r_addr;
    assign slv_wdata = r_wdata;
    assign err_cnt   = r_err_cnt;

endmodule : mio_bus_nport
`default_nettype wire
